sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
Two-requester arbiter that shares the single SDRAM controller port between the video scanout engine (port V) and the CPU/bus bridge (port C).
Each requester uses the existing SDRAM handshake: hold request until done, consume words on rdy, pulse ack to release.
The block forwards the owner's request to the SDRAM controller and returns rdy/rdata only to the owner.
Video has fixed priority, bounded by an anti-starvation limit and a grant watchdog.

Parameters:
MAX_V_CONSEC, 4, consecutive V grants allowed while C is pending before C must win
TIMEOUT, 1024, cycles a grant may be held without owner ack before forced release
TO_BITS, 11, width of watchdog counter (must hold TIMEOUT)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
v_rd_i  in  1  video read request, level, held until v_ack_i
v_addr_x16_i  in  24  video word address
v_rdy_o  out  1  video data valid
v_rdata_o  out  16  video read data
v_ack_i  in  1  video done pulse
c_rd_i  in  1  CPU read request, level
c_wr_i  in  1  CPU write request, level (never together with c_rd_i)
c_addr_x16_i  in  24  CPU word address
c_wdata_i  in  16  CPU write data
c_rdy_o  out  1  CPU data valid / write accepted
c_rdata_o  out  16  CPU read data
c_ack_i  in  1  CPU done pulse
sdram_rd_o  out  1  downstream read request
sdram_wr_o  out  1  downstream write request
sdram_addr_x16_o  out  24  downstream word address
sdram_wdata_o  out  16  downstream write data
sdram_rdy_i  in  1  downstream data valid
sdram_ack_o  out  1  downstream done pulse
sdram_rdata_i  in  16  downstream read data
owner_o  out  2  00 none, 01 V, 10 C (debug)
timeout_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (rst_ni=0 at posedge): state IDLE, owner none, streak=0, watchdog=0. All outputs 0. Reset mid-grant drops the downstream request the next cycle; no ack is issued.
- States: IDLE, GNT_V, GNT_C, TURN.
- IDLE transitions (registered):
  - V pending, and C not pending or streak<MAX_V_CONSEC -> GNT_V.
  - Else C pending (c_rd_i|c_wr_i) -> GNT_C.
  - Else stay in IDLE.
- Latency: request first seen at edge N -> owner_o and downstream request valid after edge N (cycle N+1).
- Routing is combinational from the registered owner:
  - Owner's rd/wr/addr/wdata drive sdram_*_o; other port's inputs are ignored.
  - sdram_rdy_i goes to the owner's rdy only; the other rdy stays 0.
  - rdata goes to both rdata outputs and is qualified by rdy.
  - With no owner, all sdram_*_o are 0.
- Ownership ends when the owner pulses ack:
  - sdram_ack_o = owner ack, combinational, same cycle.
  - Next state TURN. Downstream rd/wr are forced 0 from the ack cycle onward.
- TURN lasts exactly one cycle with no owner, then arbitrates as in IDLE. There are no back-to-back grants without a gap.
- Ack from a non-owner is ignored and not forwarded.
- Streak counter:
  - +1 on each V grant made while C is pending; saturates at MAX_V_CONSEC.
  - Cleared on any C grant, or on a V grant while C is idle.
- A requester that drops its request before grant is simply not granted. A requester dropping its request while owner is a protocol error; the grant persists until ack or watchdog.
- Watchdog: counts cycles in GNT_V/GNT_C, cleared on grant.
  - On reaching TIMEOUT without ack: assert sdram_ack_o for one cycle, pulse timeout_o, go to TURN.
  - A late owner ack after a forced release is ignored.
- Simultaneous ack and watchdog expiry: treat as normal ack; timeout_o stays 0.
- Simultaneous V and C requests from IDLE with streak<MAX: V wins.

Test Plan:
- Idle → V request: v_rd_i=1 at cycle 0 → owner_o=01 and sdram_rd_o=1 at cycle 1; 64 rdy pulses appear on v_rdy_o only; v_ack_i → sdram_ack_o same cycle; owner none for 1 cycle.
- Contention: V and C assert together and V re-requests immediately after each ack → grants V,V,V,V,C (MAX=4); streak returns to 0 after the C grant.
- CPU write: c_wr_i=1, addr 0x100010, data 0xBEEF → sdram_wr_o=1 with that addr/data next cycle; c_rdy_o follows sdram_rdy_i; c_ack_i releases.
- Watchdog: V granted, never acks → at grant+1024 cycles sdram_ack_o and timeout_o pulse once, then the next state is TURN, then a pending C is granted.
- Reset mid-burst: rst_ni=0 during GNT_V → next cycle all outputs 0 and owner none; after release, a new C request is granted at the normal latency.
- Stray ack: c_ack_i pulsed while V owns → no sdram_ack_o, V keeps its grant.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between video scanout (V) and the CPU bridge (C).
// Video has fixed priority, limited by a CPU anti-starvation streak and a grant watchdog.
module sdram_arbiter #(
  parameter int MAX_V_CONSEC = 4,
  parameter int TIMEOUT      = 1024,
  parameter int TO_BITS      = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        v_rd_i,
  input  logic [23:0] v_addr_x16_i,
  output logic        v_rdy_o,
  output logic [15:0] v_rdata_o,
  input  logic        v_ack_i,
  input  logic        c_rd_i,
  input  logic        c_wr_i,
  input  logic [23:0] c_addr_x16_i,
  input  logic [15:0] c_wdata_i,
  output logic        c_rdy_o,
  output logic [15:0] c_rdata_o,
  input  logic        c_ack_i,
  output logic        sdram_rd_o,
  output logic        sdram_wr_o,
  output logic [23:0] sdram_addr_x16_o,
  output logic [15:0] sdram_wdata_o,
  input  logic        sdram_rdy_i,
  output logic        sdram_ack_o,
  input  logic [15:0] sdram_rdata_i,
  output logic [1:0]  owner_o,
  output logic        timeout_o
);

  localparam int STREAK_BITS = $clog2(MAX_V_CONSEC + 1);
  localparam logic [STREAK_BITS-1:0] STREAK_MAX = STREAK_BITS'(MAX_V_CONSEC);
  localparam logic [TO_BITS-1:0]     WDOG_LIMIT = TO_BITS'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_V = 2'b01,
    ST_GNT_C = 2'b10,
    ST_TURN  = 2'b11
  } state_t;

  state_t                 state_r;
  logic [STREAK_BITS-1:0] streak_r;
  logic [TO_BITS-1:0]     wdog_r;

  logic        v_pend_s;
  logic        c_pend_s;
  logic        v_wins_s;
  logic        own_v_s;
  logic        own_c_s;
  logic        own_ack_s;
  logic        expire_s;
  logic        release_s;
  logic [15:0] shared_rdata_s;

  // Ownership decode, arbitration decision and release conditions
  always_comb begin
    v_pend_s  = v_rd_i;
    c_pend_s  = c_rd_i | c_wr_i;
    v_wins_s  = v_pend_s && (!c_pend_s || (streak_r < STREAK_MAX));
    own_v_s   = (state_r == ST_GNT_V);
    own_c_s   = (state_r == ST_GNT_C);
    own_ack_s = (own_v_s & v_ack_i) | (own_c_s & c_ack_i);
    expire_s  = (own_v_s | own_c_s) && (wdog_r == WDOG_LIMIT);
    release_s = own_ack_s | expire_s;
  end

  // Route the owner's request downstream and return rdy only to the owner
  always_comb begin
    sdram_rd_o       = 1'b0;
    sdram_wr_o       = 1'b0;
    sdram_addr_x16_o = 24'h000000;
    sdram_wdata_o    = 16'h0000;
    v_rdy_o          = 1'b0;
    c_rdy_o          = 1'b0;
    case (state_r)
      ST_GNT_V: begin
        sdram_rd_o       = v_rd_i & ~release_s;
        sdram_addr_x16_o = v_addr_x16_i;
        v_rdy_o          = sdram_rdy_i;
      end
      ST_GNT_C: begin
        sdram_rd_o       = c_rd_i & ~release_s;
        sdram_wr_o       = c_wr_i & ~release_s;
        sdram_addr_x16_o = c_addr_x16_i;
        sdram_wdata_o    = c_wdata_i;
        c_rdy_o          = sdram_rdy_i;
      end
      default: begin
        sdram_rd_o = 1'b0;
      end
    endcase
  end

  // Read data is broadcast but only non-zero while the current owner sees rdy
  always_comb begin
    if ((own_v_s | own_c_s) && sdram_rdy_i) begin
      shared_rdata_s = sdram_rdata_i;
    end else begin
      shared_rdata_s = 16'h0000;
    end
  end

  assign v_rdata_o = shared_rdata_s;
  assign c_rdata_o = shared_rdata_s;
  assign owner_o   = {own_c_s, own_v_s};
  // A release coinciding with reset is swallowed so no ack escapes downstream
  assign sdram_ack_o = release_s & rst_ni;
  assign timeout_o   = expire_s & ~own_ack_s & rst_ni;

  // Arbitration FSM with streak counter and grant watchdog
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      streak_r <= '0;
      wdog_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_TURN: begin
          wdog_r <= '0;
          if (v_wins_s) begin
            state_r <= ST_GNT_V;
            if (!c_pend_s) begin
              streak_r <= '0;
            end else if (streak_r < STREAK_MAX) begin
              streak_r <= streak_r + STREAK_BITS'(1);
            end else begin
              streak_r <= STREAK_MAX;
            end
          end else if (c_pend_s) begin
            state_r  <= ST_GNT_C;
            streak_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_V, ST_GNT_C: begin
          if (release_s) begin
            state_r <= ST_TURN;
            wdog_r  <= '0;
          end else begin
            wdog_r <= wdog_r + TO_BITS'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          streak_r <= '0;
          wdog_r   <= '0;
        end
      endcase
    end
  end

endmodule
